// File: rtl/sram_arbiter.sv
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port arbiter for the shared data SRAM. Port 0 has fixed
//               priority; port 1 is starvation-protected. The optional
//               SRAM_ARB_LOCK_EN macro adds lock1 for port-1 burst loading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_valid,
`ifdef SRAM_ARB_LOCK_EN
    input  logic                  lock1,
`endif
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_out,
    input  logic [DATA_WIDTH-1:0] sram_data_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    state_t          r_state;
    logic            r_cmd_port;
    logic            r_cmd_we;
    logic [3:0]      r_wait_cnt;

    logic                  w_lock_hold;
    logic                  w_win;
    logic                  w_win_port;
    logic                  w_win_we;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;

`ifdef SRAM_ARB_LOCK_EN
    logic r_locked;
    assign w_lock_hold = r_locked & lock1;
`else
    assign w_lock_hold = 1'b0;
`endif

    // Winner selection, only meaningful while the FSM sits in IDLE
    always_comb begin
        w_win      = 1'b0;
        w_win_port = 1'b0;
        if (w_lock_hold) begin
            if (req1) begin
                w_win      = 1'b1;
                w_win_port = 1'b1;
            end
        end else if (req1 && (r_wait_cnt == c_max_wait)) begin
            w_win      = 1'b1;
            w_win_port = 1'b1;
        end else if (req0) begin
            w_win      = 1'b1;
            w_win_port = 1'b0;
        end else if (req1) begin
            w_win      = 1'b1;
            w_win_port = 1'b1;
        end
        w_win_we    = w_win_port ? we1    : we0;
        w_win_addr  = w_win_port ? addr1  : addr0;
        w_win_wdata = w_win_port ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cmd_port    <= 1'b0;
            r_cmd_we      <= 1'b0;
            r_wait_cnt    <= 4'd0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            rvalid0       <= 1'b0;
            rvalid1       <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            sram_write_en <= 1'b0;
            sram_addr     <= '0;
            sram_data_out <= '0;
`ifdef SRAM_ARB_LOCK_EN
            r_locked      <= 1'b0;
`endif
        end else if (clk_valid) begin
            // Pulses last exactly one valid cycle
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            rvalid0       <= 1'b0;
            rvalid1       <= 1'b0;
            sram_write_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win) begin
                        r_cmd_port    <= w_win_port;
                        r_cmd_we      <= w_win_we;
                        sram_addr     <= w_win_addr;
                        sram_data_out <= w_win_wdata;
                        sram_write_en <= w_win_we;
                        gnt0          <= ~w_win_port;
                        gnt1          <= w_win_port;
                        r_state       <= S_ISSUE;
                    end
                    if (!req1 || w_lock_hold || (w_win && w_win_port)) begin
                        r_wait_cnt <= 4'd0;
                    end else if (r_wait_cnt != c_max_wait) begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
`ifdef SRAM_ARB_LOCK_EN
                    if (w_win && w_win_port && lock1) begin
                        r_locked <= 1'b1;
                    end else if (!lock1) begin
                        r_locked <= 1'b0;
                    end
`endif
                end
                S_ISSUE: begin
                    r_state <= r_cmd_we ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (r_cmd_port) begin
                        rdata1  <= sram_data_in;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= sram_data_in;
                        rvalid0 <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed, table-driven bench for sram_arbiter with a
//               behavioural synchronous 64x8 SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst, clk_valid;
    logic       req0, we0, req1, we1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       sram_write_en;
    logic [5:0] sram_addr;
    logic [7:0] sram_data_out;
    logic [7:0] sram_data_in = 8'h00;
`ifdef SRAM_ARB_LOCK_EN
    logic       lock1;
`endif

    logic [7:0] mem [64];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .clk_valid     (clk_valid),
`ifdef SRAM_ARB_LOCK_EN
        .lock1         (lock1),
`endif
        .req0          (req0),
        .we0           (we0),
        .addr0         (addr0),
        .wdata0        (wdata0),
        .gnt0          (gnt0),
        .rvalid0       (rvalid0),
        .rdata0        (rdata0),
        .req1          (req1),
        .we1           (we1),
        .addr1         (addr1),
        .wdata1        (wdata1),
        .gnt1          (gnt1),
        .rvalid1       (rvalid1),
        .rdata1        (rdata1),
        .sram_write_en (sram_write_en),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out),
        .sram_data_in  (sram_data_in)
    );

    // Synchronous SRAM: data for the presented address appears one valid cycle later
    always @(posedge clk) begin
        if (clk_valid) begin
            if (sram_write_en) mem[sram_addr] <= sram_data_out;
            sram_data_in <= mem[sram_addr];
        end
    end

    typedef struct packed {
        logic [1:0]  rc;   // {rst, clk_valid}
        logic [1:0]  p0;   // {req0, we0}
        logic [5:0]  a0;
        logic [7:0]  d0;
        logic [1:0]  p1;   // {req1, we1}
        logic [5:0]  a1;
        logic [7:0]  d1;
        logic [34:0] exp;  // {gnt0,gnt1,rvalid0,rvalid1,rdata0,rdata1,we,addr,dout}
    } vec_t;

    function automatic vec_t mk(input logic [1:0] rc, input logic [1:0] p0,
                                input logic [5:0] a0, input logic [7:0] d0,
                                input logic [1:0] p1, input logic [5:0] a1,
                                input logic [7:0] d1, input logic [3:0] pl,
                                input logic [7:0] rd0, input logic [7:0] rd1,
                                input logic swe, input logic [5:0] sa,
                                input logic [7:0] sd);
        vec_t t;
        t.rc  = rc; t.p0 = p0; t.a0 = a0; t.d0 = d0;
        t.p1  = p1; t.a1 = a1; t.d1 = d1;
        t.exp = {pl, rd0, rd1, swe, sa, sd};
        return t;
    endfunction

    function automatic logic [34:0] outs();
        return {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                sram_write_en, sram_addr, sram_data_out};
    endfunction

    task automatic drive(input vec_t t);
        rst = t.rc[1]; clk_valid = t.rc[0];
        req0 = t.p0[1]; we0 = t.p0[0]; addr0 = t.a0; wdata0 = t.d0;
        req1 = t.p1[1]; we1 = t.p1[0]; addr1 = t.a1; wdata1 = t.d1;
    endtask

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        rst = 1'b1; clk_valid = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
`ifdef SRAM_ARB_LOCK_EN
        lock1 = 1'b0;
`endif

        // Reset, idle, port 0 write/read, port 1 write, contention
        tbl.push_back(mk(2'b11, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b10, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b11, 6'h05, 8'hA5, 2'b00, 6'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 1'b1, 6'h05, 8'hA5));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h05, 8'hA5));
        tbl.push_back(mk(2'b01, 2'b10, 6'h05, 8'h00, 2'b00, 6'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0010, 8'hA5, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'hA5, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b11, 6'h3F, 8'h7E, 4'b0100, 8'hA5, 8'h00, 1'b1, 6'h3F, 8'h7E));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'hA5, 8'h00, 1'b0, 6'h3F, 8'h7E));
        tbl.push_back(mk(2'b01, 2'b10, 6'h05, 8'h00, 2'b10, 6'h3F, 8'h00, 4'b1000, 8'hA5, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b10, 6'h3F, 8'h00, 4'b0000, 8'hA5, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b10, 6'h3F, 8'h00, 4'b0010, 8'hA5, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b10, 6'h3F, 8'h00, 4'b0100, 8'hA5, 8'h00, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'hA5, 8'h00, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0001, 8'hA5, 8'h7E, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'hA5, 8'h7E, 1'b0, 6'h3F, 8'h00));
        // Port 1 read of 0x3F with clk_valid toggling every cycle
        tbl.push_back(mk(2'b11, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b10, 6'h3F, 8'h00, 4'b0100, 8'h00, 8'h00, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b00, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0100, 8'h00, 8'h00, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b00, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0001, 8'h00, 8'h7E, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b00, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0001, 8'h00, 8'h7E, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h7E, 1'b0, 6'h3F, 8'h00));
        // Reset during the ISSUE of a port 1 read, then a normal port 0 read
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b10, 6'h3F, 8'h00, 4'b0100, 8'h00, 8'h7E, 1'b0, 6'h3F, 8'h00));
        tbl.push_back(mk(2'b11, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));
        tbl.push_back(mk(2'b01, 2'b10, 6'h05, 8'h00, 2'b00, 6'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h05, 8'h00));
        tbl.push_back(mk(2'b01, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0010, 8'hA5, 8'h00, 1'b0, 6'h05, 8'h00));
        // Reset during a write ISSUE drops sram_write_en on the next cycle
        tbl.push_back(mk(2'b01, 2'b11, 6'h10, 8'h5A, 2'b00, 6'h00, 8'h00, 4'b1000, 8'hA5, 8'h00, 1'b1, 6'h10, 8'h5A));
        tbl.push_back(mk(2'b11, 2'b00, 6'h00, 8'h00, 2'b00, 6'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            tick();
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Ten idle cycles after reset: everything stays at zero
        rst = 1'b0; clk_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle%0d", i), outs(), 35'd0);
        end

        // Both ports reading continuously: 4 grants to port 0, then one to port 1
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'h05;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'h3F;
        grants = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt0 || gnt1) begin
                if (grants < 10)
                    check($sformatf("starve_gnt%0d", grants), 35'({gnt0, gnt1}),
                          (grants % 5 == 4) ? 35'b01 : 35'b10);
                grants++;
            end
            if (rvalid0) check("starve_rdata0", 35'(rdata0), 35'(8'hA5));
            if (rvalid1) check("starve_rdata1", 35'(rdata1), 35'(8'h7E));
        end
        check("starve_grant_count", 35'(grants >= 10), 35'd1);
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick();

`ifdef SRAM_ARB_LOCK_EN
        begin
            int n1;
            int n1_at_gnt0;
            rst = 1'b1; tick(); rst = 1'b0;
            lock1 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 6'h00; wdata1 = 8'h00;
            n1 = 0; n1_at_gnt0 = -1;
            for (int c = 0; c < 60 && n1_at_gnt0 < 0; c++) begin
                tick();
                req0 = 1'b1; addr0 = 6'h05; we0 = 1'b0;
                if (gnt1) begin
                    n1++;
                    addr1 = 6'(n1); wdata1 = 8'(n1);
                    if (n1 == 8) begin req1 = 1'b0; lock1 = 1'b0; end
                end
                if (gnt0) n1_at_gnt0 = n1;
            end
            check("lock_gnt0_after_8_writes", 35'(n1_at_gnt0), 35'd8);
            req0 = 1'b0;
            tick(); tick(); tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 64x8 data SRAM between two requesters:
  - port 0: control unit (high priority);
  - port 1: debug/loader master (low priority, starvation-protected).
- Sits between the requesters and the SRAM. Drives sram_write_en, sram_addr and sram_data_out, and returns sram_data_in to the winning port.
- Sequences every access through a 3-state FSM.
- All state advances only on clk edges with clk_valid=1.

Parameters:
- ADDR_WIDTH, 6, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- MAX_WAIT, 4, number of consecutive lost valid cycles after which port 1 is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high. Sampled on the clk rising edge regardless of clk_valid.
- clk_valid  in  1  cycle qualifier. When 0, all registers hold.
- req0  in  1  port 0 access request. Held until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_WIDTH  port 0 address.
- wdata0  in  DATA_WIDTH  port 0 write data.
- gnt0  out  1  port 0 command accepted (1-cycle pulse).
- rvalid0  out  1  port 0 read data valid (1-cycle pulse).
- rdata0  out  DATA_WIDTH  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- sram_write_en  out  1  to SRAM.
- sram_addr  out  ADDR_WIDTH  to SRAM.
- sram_data_out  out  DATA_WIDTH  write data to SRAM.
- sram_data_in  in  DATA_WIDTH  SRAM read data. Synchronous: valid one valid cycle after the address is presented.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all outputs 0; rdata0/rdata1=0; wait_cnt=0; internal command latch cleared.
- FSM states: IDLE, ISSUE, DATA. All transitions require clk_valid=1.
- IDLE:
  - Winner selection:
    - if req1 and wait_cnt==MAX_WAIT -> port 1;
    - else if req0 -> port 0;
    - else if req1 -> port 1;
    - else stay in IDLE.
  - On a winner: latch {port, we, addr, wdata}, go to ISSUE.
- ISSUE:
  - Drive sram_addr and sram_data_out from the latch.
  - sram_write_en = latched we.
  - gnt of the winning port = 1 for exactly this cycle.
  - Next state: DATA if read, IDLE if write.
- DATA:
  - sram_write_en=0; sram_addr held.
  - At the exit edge, capture sram_data_in into the winner's rdata register and set that port's rvalid.
  - Go to IDLE.
- rvalid/rdata:
  - rvalid is a registered pulse, high during the cycle after DATA.
  - rdata holds its value until the next read on that port.
- Outside ISSUE: sram_write_en=0. sram_addr and sram_data_out keep their last values.
- Latency (idle arbiter): read = 3 valid cycles from the req sample to rvalid; write = 2 cycles from the req sample to gnt/write.
- Throughput: a new arbitration happens in IDLE right after ISSUE (write) or DATA (read). Back-to-back requests therefore get one write per 2 cycles and one read per 3 cycles.
- Starvation counter wait_cnt (4-bit):
  - increments (saturating at MAX_WAIT) on each IDLE arbitration where req1=1 and port 0 wins;
  - cleared when port 1 wins;
  - cleared on any IDLE cycle with req1=0.
- Simultaneous req0 and req1 with wait_cnt<MAX_WAIT: port 0 wins.
- Request inputs are sampled only in IDLE. Changes to addr/wdata after the latch do not affect an in-flight access.
- Dropping req before gnt is legal; it is not sampled unless the arbiter is in IDLE.
- clk_valid=0: FSM, counters and pulses hold. A gnt/rvalid pulse stays asserted until the next valid edge.
- rst mid-access: abort immediately. No gnt/rvalid is issued for the aborted access; sram_write_en=0 next cycle.

Optional Feature:
- Macro SRAM_ARB_LOCK_EN adds input lock1 (1 bit).
- When defined: if port 1 wins with lock1=1, the arbiter grants only port 1 until an IDLE cycle with lock1=0 (burst loading). During the lock:
  - port 0 requests are ignored;
  - wait_cnt is held at 0.
- When not defined: no lock1 port; arbitration is exactly as specified above.

Test Plan:
- Reset, then no requests for 10 cycles -> all outputs 0, state IDLE, sram_write_en never asserted.
- Port 0 write addr=0x05 data=0xA5, then port 0 read addr=0x05 -> gnt0 on the 2nd cycle with sram_write_en=1; rvalid0 pulse 3 cycles after the read req with rdata0=0xA5.
- req0 and req1 held continuously (reads, MAX_WAIT=4) -> port 0 wins 4 arbitrations, port 1 wins the 5th, wait_cnt returns to 0; pattern repeats.
- clk_valid toggled 1/0 every cycle during a port 1 read of addr 0x3F=0x7E -> same sequence at half rate; rvalid1 held through the invalid cycle; rdata1=0x7E.
- rst asserted during the ISSUE of a port 1 read -> no rvalid1; next access proceeds normally from IDLE.
- SRAM_ARB_LOCK_EN defined, lock1=1, port 1 writes 0x00..0x07 with req0 also high -> all 8 writes complete before gnt0; gnt0 follows the first IDLE with lock1=0.
